inv_sub_sequencer: RTL and testbench
====================================

// Module: inv_sub_sequencer
// PURPOSE
//  Time-multiplexed inverse-SubBytes engine for the decryption round path. Accepts one
//  128-bit state, pushes it through LANES aes_invS_box instances over 16/LANES cycles,
//  and returns the full inverse-substituted state. It trades latency for S-box area
//  against the fully parallel 16-box inverse substitution layer.
//  Sits between the inverse-ShiftRows output and the AddRoundKey stage of the round controller.
// PARAMETERS
//  LANES   4   bytes substituted per cycle; legal values 1,2,4,8,16; N = 16/LANES beats per state
// PORTS
//  clk          in   1    system clock, rising edge
//  reset_n      in   1    asynchronous active-low reset
//  flush        in   1    synchronous abort; drops any state in flight
//  in_valid     in   1    in_data valid
//  in_ready     out  1    engine can accept a state
//  in_data      in   128  [0:127] state; byte i = bits [8i:8i+7]; byte 0 = bits [0:7]
//  out_valid    out  1    out_data holds a completed result
//  out_ready    in   1    downstream accepts out_data
//  out_data     out  128  [0:127] inverse-substituted state, same byte mapping as in_data
//  busy         out  1    high in BUSY state
// BEHAVIOUR
//  Reset (reset_n low, async): state=IDLE, beat counter=0, in_ready=0 while reset is asserted,
//   out_valid=0, busy=0, out_data=0, captured state register=0.
//  FSM states IDLE, BUSY, DONE. in_ready = (state==IDLE) && reset_n. busy = (state==BUSY).
//   out_valid = (state==DONE).
//  IDLE: on edge with in_valid&&in_ready, capture in_data into src register. Set beat=0.
//   Go to BUSY. Otherwise hold.
//  BUSY: each edge, bytes [beat*LANES .. beat*LANES+LANES-1] of src pass through the LANES
//   S-boxes. The results are written into the same byte positions of out_data; other bytes hold.
//   beat increments. On the edge writing beat N-1, go to DONE.
//  Latency: acceptance edge E0. Result bytes are written at edges E1..EN.
//   out_valid is high in the cycle after EN, so LANES=16 gives a 1-cycle, single-beat pass.
//  DONE: out_data and out_valid hold stable until out_valid&&out_ready.
//   On that edge go to IDLE, out_valid drops, and out_data is retained.
//   A new state is not accepted on that same edge; sustained throughput is one state per N+2 cycles.
//  Byte order: lowest byte index first (byte 0 in beat 0). S-box mapping per FIPS-197 inverse
//   table. Beat counter is ceil(log2(N)) bits, min 1 bit, and never exceeds N-1.
//  flush: highest priority after reset; on edge with flush=1 go to IDLE and set beat=0.
//   out_valid and busy drop; out_data is not cleared. flush with in_valid in IDLE does not accept.
//  in_data changes while BUSY/DONE are ignored, because src is registered at acceptance.
//  Asynchronous reset mid-BUSY or mid-DONE: immediate return to reset values; no partial result
//   is presented after release.
//  Illegal LANES (not a divisor of 16): elaboration must fail via a generate-time check.
// TESTING
//  1 LANES=4: in_data=128'h637c777bf26b6fc53001672bfed7ab76, out_ready=1 ->
//    out_data=128'h000102030405060708090a0b0c0d0e0f. out_valid appears 4 cycles after acceptance,
//    for 1 cycle.
//  2 LANES=1 and LANES=16, in_data=128'h0 -> out_data=128'h5252...52 (16 bytes).
//    out_valid appears 16 and 1 cycles after acceptance respectively.
//  3 Backpressure: all-8'hff input, out_ready=0 for 10 cycles -> out_valid stays high,
//    out_data=16x8'h7d stable, and in_ready=0 throughout. Release out_ready -> one transfer,
//    then in_ready=1 next cycle.
//  4 Change in_data to random values during BUSY -> result still matches the state captured
//    at acceptance.
//  5 Assert flush at beat 2 of 4 -> next cycle IDLE, out_valid never rises.
//    A following state 128'h63..63 yields 128'h0.
//  6 Pulse reset_n low mid-BUSY, asynchronously off-edge -> outputs go to reset values at once.
//    After release, in_ready=1 and no stale out_valid.

Source files
------------

// File: rtl/inv_sub_sequencer.sv
// Purpose : time-multiplexed AES inverse SubBytes; LANES inverse S-boxes process one 128-bit state over N=16/LANES beats.
// Latency : N cycles from the acceptance edge to out_valid; one state every N+2 cycles sustained.
// Backpressure: the result holds in DONE until out_ready; in_ready stays low while a state is in flight.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   flush                   synchronous abort of any state in flight
//   in_valid/in_ready       input handshake, in_data = 128-bit state
//   out_valid/out_ready     output handshake, out_data = inverse-substituted state
//   busy                    high while beats are being processed
// Byte i of a state sits at bits [127-8i -: 8], so byte 0 is the leftmost byte of a hex literal.

// Single inverse S-box: inverse affine transform followed by the GF(2^8) multiplicative inverse.
module aes_invS_box (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  logic [7:0] aff;
  logic [7:0] sq;
  logic [7:0] inv;

  always_comb begin
    // inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    aff = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]} ^
          {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
    // x^254 = x^-1 in GF(2^8) (and 0 -> 0): product of x^2, x^4, ..., x^128
    sq  = aff;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  assign out_byte = inv;

endmodule

module inv_sub_sequencer #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  generate
    if (LANES < 1 || LANES > 16 || (16 % LANES) != 0) begin : g_bad_lanes
      $error("inv_sub_sequencer: LANES must divide 16");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [BW-1:0] beat;
  logic [7:0]    src_b [16];
  logic [7:0]    out_b [16];

  logic [3:0]    lane_idx [LANES];
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

  // Lane l handles byte beat*LANES + l of the captured state.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 4'(int'(beat) * LANES + l);
      lane_in[l]  = src_b[lane_idx[l]];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_invS_box u_sbox (
      .in_byte  (lane_in[l]),
      .out_byte (lane_out[l])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      beat  <= '0;
      for (int i = 0; i < 16; i++) begin
        src_b[i] <= '0;
        out_b[i] <= '0;
      end
    end else if (flush) begin
      // out_data is deliberately kept; only the control path is abandoned
      state <= S_IDLE;
      beat  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < 16; i++) src_b[i] <= in_data[127-8*i -: 8];
            beat  <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          for (int l = 0; l < LANES; l++) out_b[lane_idx[l]] <= lane_out[l];
          if (beat == BW'(N - 1)) begin
            beat  <= '0;
            state <= S_DONE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_pack
    assign out_data[127-8*i -: 8] = out_b[i];
  end

  // Gate with reset_n so nothing is accepted while reset is held.
  assign in_ready  = (state == S_IDLE) && reset_n;
  assign busy      = (state == S_BUSY);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_inv_sub_sequencer.sv
module tb_inv_sub_sequencer;

  logic         clk;
  logic         reset_n;
  logic         flush     [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rnd_mode = 1'b0;
  logic [7:0] isb [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: build the forward S-box from its definition, then invert it.
  function automatic int gmul(input int a0, input int b);
    int p;
    int a;
    p = 0;
    a = a0;
    for (int i = 0; i < 8; i++) begin
      if ((b & (1 << i)) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
    end
    return p;
  endfunction

  function automatic int fwd_affine(input int b);
    int s;
    int bv;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      bv = ((b >> i) ^ (b >> ((i + 4) % 8)) ^ (b >> ((i + 5) % 8)) ^
            (b >> ((i + 6) % 8)) ^ (b >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
      s = s | (bv << i);
    end
    return s;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = isb[s[127-8*i -: 8]];
    return r;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_d
    localparam int LN = (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    localparam int NB = 16 / LN;

    inv_sub_sequencer #(.LANES(LN)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush[k]),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_data   (in_data[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k]),
      .busy      (busy[k])
    );

    logic [127:0] q[$];
    int acc = 0;

    always @(negedge reset_n) q.delete();

    // Scoreboard bookkeeping at the edge where handshakes happen.
    always @(posedge clk) begin
      if (reset_n) begin
        if (flush[k]) q.delete();
        else if (in_valid[k] && in_ready[k]) begin
          q.push_back(model(in_data[k]));
          acc = cyc;
        end else if (out_valid[k] && out_ready[k] && q.size() > 0) q.delete(0);
      end
    end

    // Checker: a state accepted at edge E0 is processed for NB edges, then presented.
    always @(negedge clk) begin
      int since;
      logic ev;
      logic eb;
      if (reset_n) begin
        since = cyc - acc;  // counts E0 itself
        eb = (q.size() > 0) && (since <= NB);
        ev = (q.size() > 0) && (since > NB);
        chk1($sformatf("in_ready[L%0d]", LN), in_ready[k], q.size() == 0);
        chk1($sformatf("busy[L%0d]", LN), busy[k], eb);
        chk1($sformatf("out_valid[L%0d]", LN), out_valid[k], ev);
        if (ev && out_valid[k]) chk128($sformatf("out_data[L%0d]", LN), out_data[k], q[0]);
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      for (int k = 0; k < 3; k++) out_ready[k] = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input int k, input logic [127:0] d);
    int n;
    n = 0;
    in_data[k]  = d;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[k]) begin
      total++;
      bad++;
      $display("FAIL send_timeout dut%0d in_ready=0 want 1", k);
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  // Waits for the engine to return to IDLE, scrambling in_data meanwhile.
  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!in_ready[k] && n < 300) begin
      in_data[k] = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[k]) begin
      total++;
      bad++;
      $display("FAIL idle_timeout dut%0d in_ready=0 want 1", k);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int inv_x;
    for (int x = 0; x < 256; x++) begin
      inv_x = 0;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv_x = y;
      isb[8'(fwd_affine(inv_x))] = 8'(x);
    end

    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      flush[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b1;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      chk1("reset in_ready", in_ready[k], 1'b0);
      chk1("reset out_valid", out_valid[k], 1'b0);
      chk1("reset busy", busy[k], 1'b0);
      chk128("reset out_data", out_data[k], 128'h0);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk1("post-reset in_ready", in_ready[k], 1'b1);

    // Known vector, LANES=4
    send(0, 128'h637c777bf26b6fc53001672bfed7ab76);
    wait_idle(0);
    chk128("vec1 retained", out_data[0], 128'h000102030405060708090a0b0c0d0e0f);

    // All-zero state on LANES=1 and LANES=16
    send(1, 128'h0);
    wait_idle(1);
    chk128("zero L1 retained", out_data[1], {16{8'h52}});
    send(2, 128'h0);
    wait_idle(2);
    chk128("zero L16 retained", out_data[2], {16{8'h52}});

    // Backpressure: result must sit in DONE while out_ready is low
    out_ready[0] = 1'b0;
    send(0, {16{8'hff}});
    repeat (15) begin
      @(posedge clk); #1;
    end
    chk1("bp out_valid held", out_valid[0], 1'b1);
    chk128("bp out_data held", out_data[0], {16{8'h7d}});
    out_ready[0] = 1'b1;
    wait_idle(0);
    chk128("bp retained", out_data[0], {16{8'h7d}});

    // Flush at beat 2 of 4
    send(0, {$urandom, $urandom, $urandom, $urandom});
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    chk1("flush in_ready", in_ready[0], 1'b1);
    chk1("flush out_valid", out_valid[0], 1'b0);
    chk1("flush busy", busy[0], 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    send(0, {16{8'h63}});
    wait_idle(0);
    chk128("after flush retained", out_data[0], 128'h0);

    // Randomized states with random backpressure and scrambled in_data
    rnd_mode = 1'b1;
    for (int it = 0; it < 24; it++) begin
      int k;
      k = $urandom_range(0, 2);
      send(k, {$urandom, $urandom, $urandom, $urandom});
      wait_idle(k);
    end
    rnd_mode = 1'b0;
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;

    // Asynchronous reset pulse mid-BUSY, away from any clock edge
    @(posedge clk); #1;
    send(0, {$urandom, $urandom, $urandom, $urandom});
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk1("async rst in_ready", in_ready[k], 1'b0);
      chk1("async rst out_valid", out_valid[k], 1'b0);
      chk1("async rst busy", busy[k], 1'b0);
      chk128("async rst out_data", out_data[k], 128'h0);
    end
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk1("post-pulse in_ready", in_ready[0], 1'b1);
    chk1("post-pulse out_valid", out_valid[0], 1'b0);
    repeat (20) begin
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
